// File: rtl/oled_spi_capture.sv
// OLED SPI receive-side decoder: oversamples cs/sclk/sdin/d_cn,
// rebuilds command bytes and RGB565 pixels, tracks frames and checksums.
module oled_spi_capture #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [12:0] pix_index,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        byte_abort
);

  localparam int N = WIDTH * HEIGHT;
  localparam logic [12:0] LAST = 13'(N - 1);

  localparam logic [0:0] ST_HIGH = 1'b0;
  localparam logic [0:0] ST_LOW  = 1'b1;

  logic r_cs_s1, r_cs_s2;
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_sdin_s1, r_sdin_s2;
  logic r_dcn_s1, r_dcn_s2;

  logic [7:0]  r_shift;
  logic [2:0]  r_bitcnt;
  logic [0:0]  r_phase;
  logic [7:0]  r_stage;
  logic [12:0] r_ptr;
  logic [15:0] r_acc;

  logic        w_rise;
  logic        w_byte_done;
  logic        w_abort;
  logic [7:0]  w_byte;
  logic [15:0] w_word;
  logic [15:0] w_sum;

  assign w_rise      = r_sclk_s2 & ~r_sclk_s3 & ~r_cs_s2;
  assign w_byte_done = w_rise & (r_bitcnt == 3'd7);
  assign w_abort     = r_cs_s2 & (r_bitcnt != 3'd0);
  assign w_byte      = {r_shift[6:0], r_sdin_s2};
  assign w_word      = {r_stage, w_byte};
  assign w_sum       = r_acc + w_word;

  // Two-flop synchronisers; cs idles high so it resets deasserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_sdin_s1 <= 1'b0;
      r_sdin_s2 <= 1'b0;
      r_dcn_s1  <= 1'b0;
      r_dcn_s2  <= 1'b0;
    end else begin
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_sdin_s1 <= sdin;
      r_sdin_s2 <= r_sdin_s1;
      r_dcn_s1  <= d_cn;
      r_dcn_s2  <= r_dcn_s1;
    end
  end

  // Bit shifter; a deselected bus holds the bit counter at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= 8'd0;
      r_bitcnt <= 3'd0;
    end else if (r_cs_s2) begin
      r_bitcnt <= 3'd0;
    end else if (w_rise) begin
      r_shift  <= w_byte;
      r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

  // Partial byte lost when cs rises before the eighth bit.
  always_ff @(posedge clk) begin
    if (reset) byte_abort <= 1'b0;
    else       byte_abort <= w_abort;
  end

  // Byte classifier, pixel half-word FSM, pointer and checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'd0;
      pix_valid  <= 1'b0;
      pix_index  <= 13'd0;
      pix_data   <= 16'd0;
      frame_done <= 1'b0;
      frame_sum  <= 16'd0;
      r_phase    <= ST_HIGH;
      r_stage    <= 8'd0;
      r_ptr      <= 13'd0;
      r_acc      <= 16'd0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (w_byte_done) begin
        if (!r_dcn_s2) begin
          cmd_byte  <= w_byte;
          cmd_valid <= 1'b1;
          r_ptr     <= 13'd0;
          r_phase   <= ST_HIGH;
          r_acc     <= 16'd0;
        end else begin
          case (r_phase)
            ST_HIGH: begin
              r_stage <= w_byte;
              r_phase <= ST_LOW;
            end
            default: begin
              pix_data  <= w_word;
              pix_index <= r_ptr;
              pix_valid <= 1'b1;
              r_phase   <= ST_HIGH;
              if (r_ptr == LAST) begin
                r_ptr      <= 13'd0;
                frame_done <= 1'b1;
                frame_sum  <= w_sum;
                r_acc      <= 16'd0;
              end else begin
                r_ptr <= r_ptr + 13'd1;
                r_acc <= w_sum;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_capture.sv
// Bench for oled_spi_capture: directed SPI traffic with a scoreboard
// of expected command/pixel/abort events checked on each pulse.
module tb_oled_spi_capture;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, sclk, sdin, d_cn;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pix_valid;
  logic [12:0] pix_index;
  logic [15:0] pix_data;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic        byte_abort;

  always #5 clk = ~clk;

  oled_spi_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk),
    .sdin(sdin), .d_cn(d_cn),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .pix_valid(pix_valid), .pix_index(pix_index),
    .pix_data(pix_data), .frame_done(frame_done),
    .frame_sum(frame_sum), .byte_abort(byte_abort)
  );

  typedef struct {
    logic [12:0] idx;
    logic [15:0] data;
    logic        fd;
    logic [15:0] fsum;
  } pix_t;

  pix_t       pq[$];
  logic [7:0] cq[$];
  int         n_abort_exp = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         half = 16;
  int         cyc = 0;
  int         last_rise = 0;

  logic [12:0] m_ptr;
  logic        m_phase;
  logic [7:0]  m_stage;
  logic [15:0] m_acc;
  logic [15:0] m_fsum;
  logic [15:0] w16;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 13'd0; m_phase = 1'b0; m_stage = 8'd0;
    m_acc = 16'd0; m_fsum = 16'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    pix_t e;
    logic [15:0] w;
    if (!dc) begin
      cq.push_back(b);
      m_ptr = 13'd0; m_phase = 1'b0; m_acc = 16'd0;
    end else if (!m_phase) begin
      m_stage = b; m_phase = 1'b1;
    end else begin
      w = {m_stage, b};
      m_phase = 1'b0;
      e.idx = m_ptr; e.data = w;
      if (int'(m_ptr) == N - 1) begin
        m_fsum = m_acc + w;
        e.fd = 1'b1; m_acc = 16'd0; m_ptr = 13'd0;
      end else begin
        e.fd = 1'b0; m_acc = m_acc + w; m_ptr = m_ptr + 13'd1;
      end
      e.fsum = m_fsum;
      pq.push_back(e);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n,
                           input logic dc);
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0; sdin = b[i]; d_cn = dc;
      repeat (half) @(negedge clk);
      sclk = 1'b1; last_rise = cyc;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    cs = 1'b0;
    model_byte(b, dc);
    send_bits(b, 8, dc);
  endtask

  task automatic drain();
    int t = 0;
    while ((cq.size() != 0 || pq.size() != 0 || n_abort_exp != 0)
           && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", t < 200, 1);
  endtask

  // Scoreboard: every pulse must match a queued expectation.
  always @(negedge clk) begin
    pix_t e;
    if (!reset) begin
      if (cmd_valid) begin
        chk("cmd_expected", cq.size() != 0, 1);
        if (cq.size() != 0) chk("cmd_byte", cmd_byte, cq.pop_front());
        chk("cmd_latency", cyc - last_rise, 3);
      end
      if (pix_valid) begin
        chk("pix_expected", pq.size() != 0, 1);
        if (pq.size() != 0) begin
          e = pq.pop_front();
          chk("pix_index", pix_index, e.idx);
          chk("pix_data", pix_data, e.data);
          chk("frame_done", frame_done, e.fd);
          chk("frame_sum", frame_sum, e.fsum);
        end
        chk("pix_latency", cyc - last_rise, 3);
      end else if (frame_done) begin
        chk("frame_done_alone", frame_done, 0);
      end
      if (byte_abort) begin
        chk("abort_expected", n_abort_exp > 0, 1);
        if (n_abort_exp > 0) n_abort_exp--;
      end
    end
  end

  initial begin
    model_reset();
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; sdin = 1'b0; d_cn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {cmd_valid, cmd_byte, pix_valid, pix_index, pix_data,
         frame_done, frame_sum, byte_abort}, 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_outs",
        {cmd_valid, cmd_byte, pix_valid, pix_index, pix_data,
         frame_done, frame_sum, byte_abort}, 0);

    send_byte(8'hAF, 1'b0);
    drain();
    chk("cmd_hold", cmd_byte, 8'hAF);

    send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'hE0, 1'b1);
    drain();
    chk("pix_hold", pix_data, 16'h07E0);

    half = 2;
    send_byte(8'h5C, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < N; p++) begin
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
      end
      drain();
      chk("frame_sum_ones", frame_sum, N);
    end
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    drain();
    chk("wrap_index", pix_index, 0);

    send_byte(8'h5C, 1'b0);
    for (int p = 0; p < N; p++) begin
      w16 = 16'($urandom);
      send_byte(w16[15:8], 1'b1);
      send_byte(w16[7:0], 1'b1);
    end
    drain();
    chk("frame_sum_rand", frame_sum, m_fsum);

    half = 4;
    cs = 1'b0;
    send_bits(8'hE7, 5, 1'b0);
    n_abort_exp++;
    cs = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h3C, 1'b0);
    drain();
    chk("abort_cmd", cmd_byte, 8'h3C);

    send_byte(8'hAB, 1'b1);
    send_byte(8'h15, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    drain();
    chk("orphan_data", pix_data, 16'h1234);

    cs = 1'b0;
    send_bits(8'hFF, 5, 1'b1);
    sclk = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("mid_reset_outs", {cmd_byte, pix_data, frame_sum}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'hA5, 1'b0);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    drain();
    cs = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_pix", {pix_index, pix_data}, {13'd0, 16'hBEEF});
    chk("queues_empty", cq.size() + pq.size() + n_abort_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
